// File: rtl/bpu_pkg.sv
// Shared constants, counter types and the saturating counter update for the
// branch prediction unit.
package bpu_pkg;

   localparam int unsigned PC_W_DEF     = 11;
   localparam int unsigned IDX_W_DEF    = 6;
   localparam int unsigned GHR_W_DEF    = 6;
   localparam int unsigned CTR_W_DEF    = 2;
   localparam int unsigned CTR_INIT_DEF = 1;   // weakly not-taken

   // Widest counter the update function supports; callers zero-extend into it.
   localparam int unsigned CTR_W_MAX = 8;

   // Named states of the default 2-bit counter.
   typedef enum logic [1:0] {
      CTR_STRONG_NT = 2'd0,
      CTR_WEAK_NT   = 2'd1,
      CTR_WEAK_T    = 2'd2,
      CTR_STRONG_T  = 2'd3
   } ctr2_e;

   typedef logic [CTR_W_MAX-1:0] ctr_t;

   // Count up on taken, down on not-taken, clamping at max and zero.
   function automatic ctr_t ctr_sat_update(input ctr_t cur, input logic taken,
                                           input ctr_t max);
      ctr_t nxt;
      nxt = cur;
      if (taken) begin
         if (cur < max) nxt = cur + ctr_t'(1);
      end else begin
         if (cur != '0) nxt = cur - ctr_t'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bpu_ghr.sv
// Global history register: speculative shift on predicted fetches, restore
// from a resolved branch's snapshot on mispredict (port 1 over port 2).
// Ports:
//   clk, reset            clock, async active-low reset
//   fetch_valid           fetch lookup advances this cycle
//   fetch_hit, fetch_pred lookup BTB hit / predicted direction
//   branchK, mispredictK, branch_takenK, ghrMK  resolved branch port K (1 older)
//   ghr                   current history (registered)
module bpu_ghr #(
   parameter int unsigned GHR_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_valid,
   input  logic             fetch_hit,
   input  logic             fetch_pred,
   input  logic             branch1,
   input  logic             mispredict1,
   input  logic             branch_taken1,
   input  logic [GHR_W-1:0] ghrM1,
   input  logic             branch2,
   input  logic             mispredict2,
   input  logic             branch_taken2,
   input  logic [GHR_W-1:0] ghrM2,
   output logic [GHR_W-1:0] ghr
);

   logic [GHR_W-1:0] restore1;
   logic [GHR_W-1:0] restore2;
   logic [GHR_W-1:0] spec;
   logic [GHR_W-1:0] ghr_next;

   // Shifted candidates; a 1-bit history is just the newest outcome.
   if (GHR_W == 1) begin : g_one
      assign restore1 = branch_taken1;
      assign restore2 = branch_taken2;
      assign spec     = fetch_pred;
   end else begin : g_shift
      assign restore1 = {ghrM1[GHR_W-2:0], branch_taken1};
      assign restore2 = {ghrM2[GHR_W-2:0], branch_taken2};
      assign spec     = {ghr[GHR_W-2:0], fetch_pred};
   end

   // Restore outranks the same-cycle speculative shift.
   always_comb begin
      ghr_next = ghr;
      if (branch1 && mispredict1) begin
         ghr_next = restore1;
      end else if (branch2 && mispredict2) begin
         ghr_next = restore2;
      end else if (fetch_valid && fetch_hit) begin
         ghr_next = spec;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ghr <= '0;
      else        ghr <= ghr_next;
   end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Branch predictor: direct-mapped BTB plus PHT of saturating counters, two
// resolved-branch update ports (port 2 wins on a shared entry).
// Macro BPU_GSHARE_EN: PHT index = pc low bits XOR history; undefined gives a
// bimodal PHT indexed by pc low bits only (history still maintained).
// Ports:
//   clk, reset                     clock, async active-low reset
//   fetch_valid, nextPC            fetch lookup
//   instMemHit/Pred/Target         combinational lookup result
//   predGhr                        history snapshot for the fetched branch
//   branchK, branch_takenK, mispredictK, pcMK, targetMK, ghrMK  update port K
module branch_predictor_gshare
   import bpu_pkg::*;
#(
   parameter int unsigned PC_W     = PC_W_DEF,
   parameter int unsigned IDX_W    = IDX_W_DEF,
   parameter int unsigned GHR_W    = GHR_W_DEF,
   parameter int unsigned CTR_W    = CTR_W_DEF,
   parameter int unsigned CTR_INIT = CTR_INIT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fetch_valid,
   input  logic [PC_W-1:0]  nextPC,
   output logic             instMemHit,
   output logic             instMemPred,
   output logic [PC_W-1:0]  instMemTarget,
   output logic [GHR_W-1:0] predGhr,
   input  logic             branch1,
   input  logic             branch2,
   input  logic             branch_taken1,
   input  logic             branch_taken2,
   input  logic             mispredict1,
   input  logic             mispredict2,
   input  logic [PC_W-1:0]  pcM1,
   input  logic [PC_W-1:0]  pcM2,
   input  logic [PC_W-1:0]  targetM1,
   input  logic [PC_W-1:0]  targetM2,
   input  logic [GHR_W-1:0] ghrM1,
   input  logic [GHR_W-1:0] ghrM2
);

   localparam int unsigned DEPTH   = 1 << IDX_W;
   localparam int unsigned TAG_W   = PC_W - IDX_W;
   localparam ctr_t        CTR_MAX = ctr_t'((1 << CTR_W) - 1);

   logic [CTR_W-1:0] pht        [DEPTH];
   logic             btb_valid  [DEPTH];
   logic [TAG_W-1:0] btb_tag    [DEPTH];
   logic [PC_W-1:0]  btb_target [DEPTH];

   logic [GHR_W-1:0] ghr;

   logic [IDX_W-1:0] f_bidx, f_pidx, u1_bidx, u1_pidx, u2_bidx, u2_pidx;
   logic [TAG_W-1:0] f_tag, u1_tag, u2_tag;
   logic             u1_hit, u2_hit;
   logic [CTR_W-1:0] u1_ctr_nxt, u2_ctr_nxt;
   logic [PC_W-1:0]  u1_tgt_nxt, u2_tgt_nxt;

   assign f_bidx  = nextPC[IDX_W-1:0];
   assign f_tag   = nextPC[PC_W-1:IDX_W];
   assign u1_bidx = pcM1[IDX_W-1:0];
   assign u1_tag  = pcM1[PC_W-1:IDX_W];
   assign u2_bidx = pcM2[IDX_W-1:0];
   assign u2_tag  = pcM2[PC_W-1:IDX_W];

   // PHT indexing: fetch uses live history, updates use the carried snapshot.
`ifdef BPU_GSHARE_EN
   assign f_pidx  = f_bidx  ^ IDX_W'(ghr);
   assign u1_pidx = u1_bidx ^ IDX_W'(ghrM1);
   assign u2_pidx = u2_bidx ^ IDX_W'(ghrM2);
`else
   assign f_pidx  = f_bidx;
   assign u1_pidx = u1_bidx;
   assign u2_pidx = u2_bidx;
`endif

   // Combinational lookup; fall-through wraps at all-ones.
   assign instMemHit    = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);
   assign instMemPred   = instMemHit && pht[f_pidx][CTR_W-1];
   assign instMemTarget = instMemPred ? btb_target[f_bidx] : nextPC + PC_W'(1);
   assign predGhr       = ghr;

   // Per-port next entry values, each computed from pre-edge contents.
   assign u1_ctr_nxt = CTR_W'(ctr_sat_update(ctr_t'(pht[u1_pidx]), branch_taken1, CTR_MAX));
   assign u2_ctr_nxt = CTR_W'(ctr_sat_update(ctr_t'(pht[u2_pidx]), branch_taken2, CTR_MAX));
   assign u1_hit     = btb_valid[u1_bidx] && (btb_tag[u1_bidx] == u1_tag);
   assign u2_hit     = btb_valid[u2_bidx] && (btb_tag[u2_bidx] == u2_tag);
   assign u1_tgt_nxt = (!u1_hit || branch_taken1) ? targetM1 : btb_target[u1_bidx];
   assign u2_tgt_nxt = (!u2_hit || branch_taken2) ? targetM2 : btb_target[u2_bidx];

   // Table writes; port 2 is written last so it overrides port 1 on a shared
   // entry, leaving exactly one update per entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pht[i]        <= CTR_W'(CTR_INIT);
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
         end
      end else begin
         if (branch1) begin
            pht[u1_pidx]        <= u1_ctr_nxt;
            btb_valid[u1_bidx]  <= 1'b1;
            btb_tag[u1_bidx]    <= u1_tag;
            btb_target[u1_bidx] <= u1_tgt_nxt;
         end
         if (branch2) begin
            pht[u2_pidx]        <= u2_ctr_nxt;
            btb_valid[u2_bidx]  <= 1'b1;
            btb_tag[u2_bidx]    <= u2_tag;
            btb_target[u2_bidx] <= u2_tgt_nxt;
         end
      end
   end

   bpu_ghr #(
      .GHR_W (GHR_W)
   ) u_ghr (
      .clk           (clk),
      .reset         (reset),
      .fetch_valid   (fetch_valid),
      .fetch_hit     (instMemHit),
      .fetch_pred    (instMemPred),
      .branch1       (branch1),
      .mispredict1   (mispredict1),
      .branch_taken1 (branch_taken1),
      .ghrM1         (ghrM1),
      .branch2       (branch2),
      .mispredict2   (mispredict2),
      .branch_taken2 (branch_taken2),
      .ghrM2         (ghrM2),
      .ghr           (ghr)
   );

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare: directed steps followed by
// random traffic checked against a table-level reference model.
module tb_branch_predictor_gshare;

   localparam int DEPTH    = 64;
   localparam int PC_SPAN  = 2048;
   localparam int GHR_MASK = 63;
   localparam int CTR_MAXV = 3;
   localparam int CTR_HALF = 2;
   localparam int CTR_RST  = 1;
`ifdef BPU_GSHARE_EN
   localparam bit GSHARE = 1'b1;
`else
   localparam bit GSHARE = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        fetch_valid;
   logic [10:0] nextPC;
   logic        instMemHit;
   logic        instMemPred;
   logic [10:0] instMemTarget;
   logic [5:0]  predGhr;
   logic        branch1, branch2;
   logic        branch_taken1, branch_taken2;
   logic        mispredict1, mispredict2;
   logic [10:0] pcM1, pcM2, targetM1, targetM2;
   logic [5:0]  ghrM1, ghrM2;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state (m_) and next-state scratch (n_).
   int m_cnt [DEPTH];
   bit m_val [DEPTH];
   int m_tag [DEPTH];
   int m_tgt [DEPTH];
   int m_ghr;
   int n_cnt [DEPTH];
   bit n_val [DEPTH];
   int n_tag [DEPTH];
   int n_tgt [DEPTH];
   int n_ghr;
   bit e_hit, e_pred;
   int e_tgt;

   branch_predictor_gshare dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_valid   (fetch_valid),
      .nextPC        (nextPC),
      .instMemHit    (instMemHit),
      .instMemPred   (instMemPred),
      .instMemTarget (instMemTarget),
      .predGhr       (predGhr),
      .branch1       (branch1),
      .branch2       (branch2),
      .branch_taken1 (branch_taken1),
      .branch_taken2 (branch_taken2),
      .mispredict1   (mispredict1),
      .mispredict2   (mispredict2),
      .pcM1          (pcM1),
      .pcM2          (pcM2),
      .targetM1      (targetM1),
      .targetM2      (targetM2),
      .ghrM1         (ghrM1),
      .ghrM2         (ghrM2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pidx(input int pc, input int h);
      return (pc % DEPTH) ^ (GSHARE ? h : 0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_cnt[i] = CTR_RST;
         m_val[i] = 1'b0;
         m_tag[i] = 0;
         m_tgt[i] = 0;
      end
      m_ghr = 0;
   endtask

   // Compare current outputs against the model's view of the lookup.
   task automatic lookup_check();
      int pc, b;
      pc     = int'(nextPC);
      b      = pc % DEPTH;
      e_hit  = m_val[b] && (m_tag[b] == pc / DEPTH);
      e_pred = e_hit && (m_cnt[pidx(pc, m_ghr)] >= CTR_HALF);
      e_tgt  = e_pred ? m_tgt[b] : (pc + 1) % PC_SPAN;
      check("hit",    32'(instMemHit),    32'(e_hit));
      check("pred",   32'(instMemPred),   32'(e_pred));
      check("target", 32'(instMemTarget), 32'(e_tgt));
      check("ghr",    32'(predGhr),       32'(m_ghr));
   endtask

   // One resolved branch, evaluated from the old model state.
   task automatic apply_port(input bit br, input bit tk, input int pc, input int tgt,
                             input int h);
      int p, b, t;
      if (!br) return;
      p = pidx(pc, h);
      b = pc % DEPTH;
      t = pc / DEPTH;
      if (tk) n_cnt[p] = (m_cnt[p] == CTR_MAXV) ? CTR_MAXV : m_cnt[p] + 1;
      else    n_cnt[p] = (m_cnt[p] == 0) ? 0 : m_cnt[p] - 1;
      n_val[b] = 1'b1;
      n_tag[b] = t;
      if (!m_val[b] || m_tag[b] != t) n_tgt[b] = tgt;
      else                            n_tgt[b] = tk ? tgt : m_tgt[b];
   endtask

   task automatic model_next();
      n_cnt = m_cnt;
      n_val = m_val;
      n_tag = m_tag;
      n_tgt = m_tgt;
      apply_port(branch1, branch_taken1, int'(pcM1), int'(targetM1), int'(ghrM1));
      apply_port(branch2, branch_taken2, int'(pcM2), int'(targetM2), int'(ghrM2));
      if (branch1 && mispredict1)      n_ghr = ((int'(ghrM1) << 1) | int'(branch_taken1)) & GHR_MASK;
      else if (branch2 && mispredict2) n_ghr = ((int'(ghrM2) << 1) | int'(branch_taken2)) & GHR_MASK;
      else if (fetch_valid && e_hit)   n_ghr = ((m_ghr << 1) | int'(e_pred)) & GHR_MASK;
      else                             n_ghr = m_ghr;
   endtask

   // Check, advance one clock, commit model; returns at the next negedge.
   task automatic cycle();
      lookup_check();
      model_next();
      @(posedge clk);
      m_cnt = n_cnt;
      m_val = n_val;
      m_tag = n_tag;
      m_tgt = n_tgt;
      m_ghr = n_ghr;
      @(negedge clk);
   endtask

   task automatic idle();
      fetch_valid   = 1'b0;
      branch1       = 1'b0;
      branch2       = 1'b0;
      branch_taken1 = 1'b0;
      branch_taken2 = 1'b0;
      mispredict1   = 1'b0;
      mispredict2   = 1'b0;
      pcM1 = '0; pcM2 = '0; targetM1 = '0; targetM2 = '0; ghrM1 = '0; ghrM2 = '0;
   endtask

   task automatic drive_b1(input logic [10:0] pc, input logic [10:0] tgt, input bit tk,
                           input logic [5:0] h, input bit misp);
      branch1 = 1'b1; pcM1 = pc; targetM1 = tgt; branch_taken1 = tk; ghrM1 = h; mispredict1 = misp;
   endtask

   task automatic drive_b2(input logic [10:0] pc, input logic [10:0] tgt, input bit tk,
                           input logic [5:0] h, input bit misp);
      branch2 = 1'b1; pcM2 = pc; targetM2 = tgt; branch_taken2 = tk; ghrM2 = h; mispredict2 = misp;
   endtask

   // Single taken/not-taken update of one pc through port 1, with lookup of it.
   task automatic train1(input logic [10:0] pc, input logic [10:0] tgt, input bit tk);
      idle();
      drive_b1(pc, tgt, tk, 6'h00, 1'b0);
      nextPC = pc;
      #1;
      cycle();
   endtask

   initial begin
      // Reset state with an all-ones fetch PC.
      idle();
      reset  = 1'b0;
      nextPC = 11'h7FF;
      model_reset();
      #1;
      check("rst_hit",    32'(instMemHit),    32'h0);
      check("rst_pred",   32'(instMemPred),   32'h0);
      check("rst_target", 32'(instMemTarget), 32'h000);
      check("rst_ghr",    32'(predGhr),       32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Allocate 0x045 -> 0x120; the update cycle itself still misses.
      idle();
      drive_b1(11'h045, 11'h120, 1'b1, 6'h00, 1'b0);
      nextPC = 11'h045;
      #1;
      check("same_cycle_miss", 32'(instMemHit), 32'h0);
      cycle();
      train1(11'h045, 11'h120, 1'b1);
      idle();
      nextPC = 11'h045;
      #1;
      check("trained_hit",    32'(instMemHit),    32'h1);
      check("trained_pred",   32'(instMemPred),   32'h1);
      check("trained_target", 32'(instMemTarget), 32'h120);
      cycle();

      // Saturation at the top: five more taken, then one not-taken still predicts taken.
      for (int i = 0; i < 5; i++) train1(11'h045, 11'h120, 1'b1);
      train1(11'h045, 11'h120, 1'b0);
      idle();
      nextPC = 11'h045;
      #1;
      check("sat_hi_pred", 32'(instMemPred), 32'h1);
      cycle();
      // Saturation at zero: drive below zero, then one taken stays not-taken, two flips.
      for (int i = 0; i < 3; i++) train1(11'h045, 11'h120, 1'b0);
      train1(11'h045, 11'h120, 1'b1);
      idle();
      nextPC = 11'h045;
      #1;
      check("sat_lo_pred1", 32'(instMemPred), 32'h0);
      check("nt_keeps_tgt", 32'(instMemTarget), 32'h046);
      cycle();
      train1(11'h045, 11'h120, 1'b1);
      idle();
      nextPC = 11'h045;
      #1;
      check("sat_lo_pred2", 32'(instMemPred),   32'h1);
      check("sat_lo_tgt",   32'(instMemTarget), 32'h120);
      cycle();

      // Both ports on 0x010 in one cycle: port 2 (not-taken) alone applies.
      idle();
      drive_b1(11'h010, 11'h200, 1'b1, 6'h00, 1'b0);
      drive_b2(11'h010, 11'h300, 1'b0, 6'h00, 1'b0);
      nextPC = 11'h010;
      #1;
      cycle();
      idle();
      nextPC = 11'h010;
      #1;
      check("dual_hit",    32'(instMemHit),    32'h1);
      check("dual_pred",   32'(instMemPred),   32'h0);
      check("dual_target", 32'(instMemTarget), 32'h011);
      cycle();
      train1(11'h010, 11'h200, 1'b1);
      idle();
      nextPC = 11'h010;
      #1;
      check("dual_single_count", 32'(instMemPred), 32'h0);
      cycle();

      // History restore outranks a same-cycle speculative shift.
      idle();
      drive_b1(11'h045, 11'h120, 1'b0, 6'b010101, 1'b1);
      nextPC = 11'h045;
      #1;
      cycle();
      idle();
      fetch_valid = 1'b1;
      nextPC      = 11'h045;
      drive_b2(11'h0A0, 11'h0A8, 1'b0, 6'b000111, 1'b1);
      #1;
      check("ghr_before", 32'(predGhr), 32'h2A);
      cycle();
      idle();
      nextPC = 11'h045;
      #1;
      check("ghr_restore", 32'(predGhr), 32'h0E);
      cycle();

      // Reset during an active update drops it entirely.
      idle();
      drive_b1(11'h045, 11'h120, 1'b1, 6'h00, 1'b1);
      nextPC = 11'h045;
      #1;
      reset = 1'b0;
      #1;
      check("midrst_hit",    32'(instMemHit),    32'h0);
      check("midrst_target", 32'(instMemTarget), 32'h046);
      check("midrst_ghr",    32'(predGhr),       32'h0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      idle();
      reset = 1'b1;
      #1;
      cycle();

`ifndef BPU_GSHARE_EN
      // Bimodal: entry 3 predicts from pc alone whatever the history.
      for (int i = 0; i < 2; i++) begin
         idle();
         drive_b1(11'h003, 11'h155, 1'b1, 6'h1F, 1'b1);
         nextPC = 11'h003;
         #1;
         cycle();
      end
      idle();
      nextPC = 11'h003;
      #1;
      check("bimodal_ghr",    32'(predGhr),       32'h3F);
      check("bimodal_pred",   32'(instMemPred),   32'h1);
      check("bimodal_target", 32'(instMemTarget), 32'h155);
      cycle();
`endif

      // Random traffic on a small pc pool so entries alias and collide.
      for (int n = 0; n < 400; n++) begin
         idle();
         fetch_valid = 1'($urandom_range(0, 1));
         nextPC      = 11'({$urandom_range(0, 1), 6'($urandom_range(0, 15))});
         if ($urandom_range(0, 1) == 1)
            drive_b1(11'({$urandom_range(0, 1), 6'($urandom_range(0, 15))}), 11'($urandom),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? predGhr : 6'($urandom),
                     $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1)
            drive_b2(11'({$urandom_range(0, 1), 6'($urandom_range(0, 15))}), 11'($urandom),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 1) ? predGhr : 6'($urandom),
                     $urandom_range(0, 3) == 0);
         #1;
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
 PC_W, 11, PC/target width.
 IDX_W, 6, table index width; depth = 2^IDX_W.
 GHR_W, 6, global history length; legal range 1..IDX_W.
 CTR_W, 2, saturating counter width.
 CTR_INIT, 1, counter reset value (weakly not-taken).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge.
 reset  in  1  asynchronous, active-low reset.
 fetch_valid  in  1  fetch lookup advances this cycle.
 nextPC  in  PC_W  fetch PC looked up.
 instMemHit  out  1  BTB tag hit for nextPC.
 instMemPred  out  1  predicted taken.
 instMemTarget  out  PC_W  predicted next fetch PC.
 predGhr  out  GHR_W  history snapshot, carried down the pipe with the branch.
 branch1/branch2  in  1  resolved branch valid, port 1 older.
 branch_taken1/2  in  1  resolved outcome.
 mispredict1/2  in  1  resolved direction or target was wrong.
 pcM1/pcM2  in  PC_W  resolved branch PC.
 targetM1/2  in  PC_W  resolved taken target.
 ghrM1/ghrM2  in  GHR_W  predGhr snapshot of that branch.

Function
REQ-003 BTB index SHALL be pc[IDX_W-1:0]; tag SHALL be pc[PC_W-1:IDX_W] (full upper bits, no aliasing).
REQ-004 PHT index SHALL be pc[IDX_W-1:0] XOR zero-extended history (GHR at fetch, ghrMk at update).
REQ-005 Lookup SHALL be combinational: instMemHit = valid & tag match; instMemPred = instMemHit & counter MSB.
REQ-006 instMemTarget SHALL be the BTB target when instMemPred=1, else nextPC+1 modulo 2^PC_W (wraps at all-ones).
REQ-007 predGhr SHALL equal the current GHR.
REQ-008 GHR next-state priority SHALL be: (a) branch1&mispredict1 -> {ghrM1[GHR_W-2:0], branch_taken1}; (b) else branch2&mispredict2 -> same using port 2; (c) else fetch_valid&instMemHit -> {GHR[GHR_W-2:0], instMemPred}; (d) else hold. For GHR_W=1, the shift SHALL degenerate to the new bit alone.
REQ-009 On branchk, the PHT counter SHALL increment if taken and decrement if not, saturating at 2^CTR_W-1 and 0.
REQ-010 On branchk with tag miss or invalid, the BTB entry SHALL be allocated: valid=1, tag written, target=targetMk.
REQ-011 On branchk with tag hit, target SHALL be overwritten only when taken; a not-taken outcome SHALL leave it unchanged.
REQ-012 If both ports address the same PHT or BTB entry in one cycle, port 2 SHALL win, computed from the pre-edge value; a single update, no double count.
REQ-013 Updates SHALL take effect at the clock edge; a same-cycle lookup SHALL see the old contents; update-to-lookup latency SHALL be 1 cycle.
REQ-014 A mispredict restore SHALL discard the same-cycle speculative fetch history update.

Reset
REQ-015 While reset=0: all counters = CTR_INIT, valid = 0, tags/targets = 0, GHR = 0, asynchronously.
REQ-016 Outputs during and after reset SHALL be instMemHit=0, instMemPred=0, instMemTarget=nextPC+1, predGhr=0.
REQ-017 Reset asserted mid-operation SHALL drop all in-flight updates; no partial table write.

Configuration
REQ-018 Macro BPU_GSHARE_EN defined: PHT indexing SHALL follow REQ-004.
REQ-019 Macro BPU_GSHARE_EN undefined: PHT index SHALL be pc[IDX_W-1:0] only (bimodal); the GHR and predGhr SHALL still be maintained per REQ-008.

Structure
REQ-020 Package bpu_pkg SHALL hold default parameter constants, the counter-state typedef and the saturating-update function.
REQ-021 The GHR with speculative shift and restore mux SHALL be sub-module bpu_ghr; the tables stay in the top module.

Verification (defaults, GSHARE_EN defined unless noted)
REQ-022 Reset, nextPC=11'h7FF -> instMemHit=0, instMemPred=0, instMemTarget=11'h000, predGhr=0.
REQ-023 branch1, taken, pcM1=0x045, targetM1=0x120, ghrM1=0, twice; then nextPC=0x045 with GHR=0 -> hit=1, pred=1, target=0x120.
REQ-024 Counter 3 plus five taken updates -> stays 3; counter 0 plus not-taken -> stays 0.
REQ-025 Same cycle: branch1 taken and branch2 not-taken, both pcM=0x010, ghrM=0, counter 1 -> counter becomes 0; target follows port 2 rules.
REQ-026 GHR=6'b101010, fetch_valid hit pred=1, same cycle mispredict2 with ghrM2=6'b000111, taken=0 -> GHR becomes 6'b001110.
REQ-027 BPU_GSHARE_EN undefined: train pcM=0x003 with ghrM=6'h3F -> lookup nextPC=0x003 predicts from entry 3 regardless of GHR.
